alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream neighbour of the 16-bit ALU, which registers its result twice and so has a 2-edge latency from FunSel/A/B to ALUOut/FlagsOut.
- Tracks each issued ALU operation through that latency and captures ALUOut/FlagsOut on the correct edge.
- Maintains the architectural flag register {Z,C,N,O} with per-op update masks and feeds the carry back to the ALU.
- Buffers results in a small FIFO toward the register-file write port, with valid/ready handshakes on both sides.

Parameters:
- ALU_LATENCY, 2, edges from issue accept to result valid on ALUOut/FlagsOut; legal range 1..4.
- FIFO_DEPTH, 2, result buffer entries; power of two, 2..8.
- DEST_W, 3, width of the destination tag carried with each op.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- IssueValid  input  1  an ALU op is presented this cycle.
- IssueReady  output  1  stage accepts the op; accept = IssueValid & IssueReady.
- IssueFlagMask  input  4  per-flag update enable {Z,C,N,O} for this op.
- IssueDest  input  DEST_W  destination tag for this op.
- ALUOut  input  16  ALU result.
- FlagsOut  input  4  ALU flags {Z,C,N,O}.
- Flush  input  1  discard all in-flight and buffered results.
- ResValid  output  1  FIFO head valid.
- ResReady  input  1  consumer takes the head; pop = ResValid & ResReady.
- ResData  output  16  head result.
- ResDest  output  DEST_W  head tag.
- Flags  output  4  architectural flag register {Z,C,N,O}.
- CarryOut  output  1  equals Flags[2]; drives the ALU carry input.
- ClearSticky  input  1  clears StickyOvf (used only with the optional feature).
- StickyOvf  output  1  sticky overflow flag.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - All delay-line valids 0; FIFO empty; count 0.
  - ResValid 0; ResData 0; ResDest 0.
  - Flags 4'b0000; CarryOut 0; StickyOvf 0.
- Delay line: ALU_LATENCY stages of {valid, mask, dest}, shifting every cycle (no stall).
  - On accept, stage 0 is loaded with {1, IssueFlagMask, IssueDest}; otherwise stage 0 valid is 0.
- Capture:
  - When the last stage is valid, push {ALUOut, dest} into the FIFO on that same edge.
  - On that edge, Flags[i] <= mask[i] ? FlagsOut[i] : Flags[i].
  - Consequence: an op accepted at edge E has its result in the FIFO after edge E+ALU_LATENCY. With an empty FIFO, ResValid is first high in the cycle after that edge.
- Credit:
  - outstanding = (valid delay-line stages) + FIFO count.
  - IssueReady = (outstanding < FIFO_DEPTH) & ~Flush, computed from registered state only. A same-cycle pop does not free a credit.
  - This guarantees the FIFO never overflows. Push while full is an assertion failure.
- FIFO:
  - First-word fall-through: ResData/ResDest show the head whenever ResValid = 1.
  - Simultaneous push and pop is legal; count is unchanged.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags are written only at capture. Ops in flight never see earlier flags forwarded, so the issuer must not issue a carry-dependent op while a carry-writing op is still in flight.
- Flush (synchronous, one cycle):
  - Clears all delay-line valids, the FIFO and the count.
  - An op capturing on the same edge is dropped and its flags are not written.
  - Flags and StickyOvf are kept. Issue is refused that cycle.
- Reset asserted mid-operation overrides everything, including Flush and capture.
- Results and flags are written in issue order; there is no reordering.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STICKY_OVF_EN.
- Defined:
  - StickyOvf is set on any capture where mask[0] = 1 and FlagsOut[0] = 1.
  - It is cleared by ClearSticky; if set and clear occur on the same edge, set wins.
  - Flush does not clear it.
- Undefined: StickyOvf is tied 0 and ClearSticky is ignored (port still present).

Decomposition:
- Shared package alu_pkg:
  - Flag index constants FLAG_Z = 3, FLAG_C = 2, FLAG_N = 1, FLAG_O = 0.
  - Typedef for the 4-bit flag vector.
  - Typedef for the delay-line entry {valid, mask, dest}.
- One sub-module: result_fifo (parameterised depth/width, first-word fall-through, push/pop/flush, count output). The delay line and flag logic stay in the top module.

Test Plan:
- Reset then idle: all outputs 0, IssueReady = 1.
- Single op: accept at edge E, drive ALUOut = 16'h0000, FlagsOut = 4'b1100 at capture, mask 4'b1111, dest 3'd5 -> ResValid high after edge E+2, ResData 0x0000, ResDest 5, Flags 4'b1100, CarryOut 1.
- Masked update: Flags = 4'b1100, op with mask 4'b0010, FlagsOut = 4'b0011 -> Flags becomes 4'b1110.
- Backpressure: ResReady = 0, issue every cycle -> exactly 2 accepted, IssueReady = 0; one pop -> IssueReady returns 1 the following cycle; order and tags preserved.
- Flush with 1 in flight and 1 buffered, plus a capture on the same edge -> ResValid 0 next cycle, Flags unchanged, no later ResValid.
- With ALU_RESULT_STAGE_STICKY_OVF_EN: capture with FlagsOut = 4'b0001, mask bit 0 set -> StickyOvf 1; ClearSticky -> 0; ClearSticky on the same edge as a new overflow -> stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared flag indices and delay-line types for the ALU result stage
package alu_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    // Widest destination tag a delay-line entry can carry; narrower tags are zero-extended
    localparam int DEST_MAX_W = 8;

    typedef logic [3:0] flags_t;

    typedef struct packed {
        logic                  valid;
        flags_t                mask;
        logic [DEST_MAX_W-1:0] dest;
    } stage_t;

    function automatic flags_t merge_flags(flags_t cur, flags_t upd, flags_t mask);
        return (upd & mask) | (cur & ~mask);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word fall-through result buffer with flush and occupancy count
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 19
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       valid,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             full;

    assign full   = (cnt == CW'(DEPTH));
    assign do_pop = pop & (cnt != '0);
    assign valid  = (cnt != '0);
    assign head   = valid ? mem[rptr] : '0;
    assign count  = cnt;

    always_ff @(posedge Clock) begin
        if (Reset || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            assert (!(push && full));
            if (push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head is masked to zero while empty
    always_ff @(posedge Clock) begin
        if (push && !flush && !Reset)
            mem[wptr] <= push_data;
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU latency tracker, flag register and result buffer; ALU_RESULT_STAGE_STICKY_OVF_EN adds sticky overflow
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int DEST_W      = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IssueValid,
    output logic              IssueReady,
    input  logic [3:0]        IssueFlagMask,
    input  logic [DEST_W-1:0] IssueDest,
    input  logic [15:0]       ALUOut,
    input  logic [3:0]        FlagsOut,
    input  logic              Flush,
    output logic              ResValid,
    input  logic              ResReady,
    output logic [15:0]       ResData,
    output logic [DEST_W-1:0] ResDest,
    output logic [3:0]        Flags,
    output logic              CarryOut,
    input  logic              ClearSticky,
    output logic              StickyOvf
);

    localparam int CW  = $clog2(FIFO_DEPTH + ALU_LATENCY + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int RW  = 16 + DEST_W;

    stage_t           stage_q [ALU_LATENCY];
    flags_t           flags_q;
    logic             accept;
    logic             capture;
    logic [CW-1:0]    inflight;
    logic [FCW-1:0]   fifo_count;
    logic [RW-1:0]    fifo_head;

    // Credits come from registered state only, so a same-cycle pop never frees a slot
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ALU_LATENCY; i++)
            inflight = inflight + CW'(stage_q[i].valid);
    end

    assign IssueReady = ((inflight + CW'(fifo_count)) < CW'(FIFO_DEPTH)) & ~Flush;
    assign accept     = IssueValid & IssueReady;
    assign capture    = stage_q[ALU_LATENCY-1].valid & ~Flush;

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            for (int i = 0; i < ALU_LATENCY; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0].valid <= accept;
            stage_q[0].mask  <= IssueFlagMask;
            stage_q[0].dest  <= DEST_MAX_W'(IssueDest);
            for (int i = 1; i < ALU_LATENCY; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            flags_q <= '0;
        else if (capture)
            flags_q <= merge_flags(flags_q, FlagsOut, stage_q[ALU_LATENCY-1].mask);
    end

    assign Flags    = flags_q;
    assign CarryOut = flags_q[FLAG_C];

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (capture),
        .push_data ({ALUOut, stage_q[ALU_LATENCY-1].dest[DEST_W-1:0]}),
        .pop       (ResReady),
        .flush     (Flush),
        .valid     (ResValid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign ResData = fifo_head[RW-1:DEST_W];
    assign ResDest = fifo_head[DEST_W-1:0];

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    logic sticky_q;

    // A new overflow beats a clear on the same edge
    always_ff @(posedge Clock) begin
        if (Reset)
            sticky_q <= 1'b0;
        else if (capture && stage_q[ALU_LATENCY-1].mask[FLAG_O] && FlagsOut[FLAG_O])
            sticky_q <= 1'b1;
        else if (ClearSticky)
            sticky_q <= 1'b0;
    end

    assign StickyOvf = sticky_q;
`else
    logic unused_clear_sticky;
    assign unused_clear_sticky = ClearSticky;
    assign StickyOvf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and randomized check of alu_result_stage against an edge-count reference model
module tb_alu_result_stage;

    localparam int L  = 2;
    localparam int D  = 2;
    localparam int DW = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          IssueValid;
    logic          IssueReady;
    logic [3:0]    IssueFlagMask;
    logic [DW-1:0] IssueDest;
    logic [15:0]   ALUOut;
    logic [3:0]    FlagsOut;
    logic          Flush;
    logic          ResValid;
    logic          ResReady;
    logic [15:0]   ResData;
    logic [DW-1:0] ResDest;
    logic [3:0]    Flags;
    logic          CarryOut;
    logic          ClearSticky;
    logic          StickyOvf;

    alu_result_stage #(.ALU_LATENCY(L), .FIFO_DEPTH(D), .DEST_W(DW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .IssueValid    (IssueValid),
        .IssueReady    (IssueReady),
        .IssueFlagMask (IssueFlagMask),
        .IssueDest     (IssueDest),
        .ALUOut        (ALUOut),
        .FlagsOut      (FlagsOut),
        .Flush         (Flush),
        .ResValid      (ResValid),
        .ResReady      (ResReady),
        .ResData       (ResData),
        .ResDest       (ResDest),
        .Flags         (Flags),
        .CarryOut      (CarryOut),
        .ClearSticky   (ClearSticky),
        .StickyOvf     (StickyOvf)
    );

    always #5 Clock = ~Clock;

    // Model: each op remembers the edge it was accepted on and lands L edges later
    typedef struct { int e; logic [3:0] m; logic [DW-1:0] d; } op_t;
    typedef struct { logic [15:0] data; logic [DW-1:0] dest; } res_t;

    op_t        infl[$];
    res_t       fq[$];
    logic [3:0] mflags;
    logic       msticky;
    int         edge_no;
    int         checks;
    int         failures;

`ifdef ALU_RESULT_STAGE_STICKY_OVF_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return ((infl.size() + fq.size()) < D) && !Flush;
    endfunction

    task automatic check_all();
        res_t h;
        h.data = '0;
        h.dest = '0;
        if (fq.size() > 0)
            h = fq[0];
        chk("IssueReady", 16'(IssueReady), 16'(model_ready()));
        chk("ResValid", 16'(ResValid), 16'(fq.size() > 0));
        chk("ResData", ResData, h.data);
        chk("ResDest", 16'(ResDest), 16'(h.dest));
        chk("Flags", 16'(Flags), 16'(mflags));
        chk("CarryOut", 16'(CarryOut), 16'(mflags[2]));
        chk("StickyOvf", 16'(StickyOvf), 16'(msticky));
    endtask

    task automatic model_edge();
        bit   acc;
        bit   set;
        op_t  o;
        res_t r;
        acc = IssueValid && model_ready();
        set = 1'b0;
        if (Reset) begin
            infl.delete();
            fq.delete();
            mflags  = 4'b0000;
            msticky = 1'b0;
        end else if (Flush) begin
            infl.delete();
            fq.delete();
            if (ClearSticky) msticky = 1'b0;
        end else begin
            if (ResReady && fq.size() > 0)
                void'(fq.pop_front());
            if (infl.size() > 0 && infl[0].e + L == edge_no) begin
                o = infl.pop_front();
                r.data = ALUOut;
                r.dest = o.d;
                fq.push_back(r);
                for (int i = 0; i < 4; i++)
                    if (o.m[i]) mflags[i] = FlagsOut[i];
                set = o.m[0] && FlagsOut[0];
            end
            if (STICKY_ON)
                msticky = set ? 1'b1 : (ClearSticky ? 1'b0 : msticky);
            if (acc) begin
                o.e = edge_no;
                o.m = IssueFlagMask;
                o.d = IssueDest;
                infl.push_back(o);
            end
        end
        edge_no++;
    endtask

    task automatic cycle();
        @(negedge Clock);
        check_all();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [3:0] m, input logic [DW-1:0] d);
        IssueValid    = 1'b1;
        IssueFlagMask = m;
        IssueDest     = d;
        cycle();
        IssueValid    = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; edge_no = 0;
        mflags = 4'b0000; msticky = 1'b0;
        Reset = 1'b1; IssueValid = 1'b0; IssueFlagMask = 4'h0; IssueDest = '0;
        ALUOut = 16'h0; FlagsOut = 4'h0; Flush = 1'b0; ResReady = 1'b0; ClearSticky = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        cycle();
        chk("idle_ready", 16'(IssueReady), 16'd1);

        // Single op, full mask, tag 5
        ALUOut = 16'hBEEF; FlagsOut = 4'b0011;
        issue(4'b1111, 3'd5);
        ALUOut = 16'h0000; FlagsOut = 4'b1100;
        cycle();
        chk("single_not_yet", 16'(ResValid), 16'd0);
        cycle();
        chk("single_valid", 16'(ResValid), 16'd1);
        chk("single_data", ResData, 16'h0000);
        chk("single_dest", 16'(ResDest), 16'd5);
        chk("single_flags", 16'(Flags), 16'b1100);
        chk("single_carry", 16'(CarryOut), 16'd1);
        ResReady = 1'b1;
        cycle();

        // Masked update touches only N
        issue(4'b0010, 3'd2);
        FlagsOut = 4'b0011; ALUOut = 16'h1234;
        repeat (2) cycle();
        chk("masked_flags", 16'(Flags), 16'b1110);
        cycle();

        // Backpressure: only two credits
        ResReady = 1'b0; IssueValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            IssueDest = DW'(i + 1); IssueFlagMask = 4'h0; ALUOut = 16'(16'h100 + i);
            cycle();
        end
        chk("bp_blocked", 16'(IssueReady), 16'd0);
        IssueValid = 1'b0; ResReady = 1'b1;
        cycle();
        ResReady = 1'b0;
        chk("bp_credit_back", 16'(IssueReady), 16'd1);
        ResReady = 1'b1;
        repeat (3) cycle();

        // Flush with one buffered and one capturing on the flush edge
        ResReady = 1'b0; FlagsOut = 4'b0101; ALUOut = 16'hAAAA;
        issue(4'b1111, 3'd1);
        issue(4'b1111, 3'd2);
        cycle();
        Flush = 1'b1;
        cycle();
        Flush = 1'b0;
        chk("flush_empty", 16'(ResValid), 16'd0);
        repeat (4) cycle();
        chk("flush_no_late", 16'(ResValid), 16'd0);

        // Sticky overflow set, clear, and set-wins collision
        ResReady = 1'b1; FlagsOut = 4'b0001;
        issue(4'b0001, 3'd3);
        repeat (2) cycle();
        chk("sticky_set", 16'(StickyOvf), 16'(STICKY_ON));
        ClearSticky = 1'b1;
        cycle();
        ClearSticky = 1'b0;
        chk("sticky_clear", 16'(StickyOvf), 16'd0);
        issue(4'b0001, 3'd4);
        cycle();
        ClearSticky = 1'b1;
        cycle();
        ClearSticky = 1'b0;
        chk("sticky_set_wins", 16'(StickyOvf), 16'(STICKY_ON));

        // Randomized traffic, including mid-run flushes and resets
        for (int n = 0; n < 600; n++) begin
            IssueValid    = ($urandom_range(0, 3) != 0);
            IssueFlagMask = 4'($urandom);
            IssueDest     = DW'($urandom);
            ALUOut        = 16'($urandom);
            FlagsOut      = 4'($urandom);
            ResReady      = ($urandom_range(0, 2) != 0);
            Flush         = ($urandom_range(0, 15) == 0);
            ClearSticky   = ($urandom_range(0, 7) == 0);
            Reset         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        Reset = 1'b0; Flush = 1'b0; IssueValid = 1'b0; ResReady = 1'b1;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
